alu_muldiv: RTL

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a parametrised datapath width. It sits in the execute stage beside the single-cycle ALU. The execute stage routes OPCODE_OP instructions with funct7 = F7_MULDIV here. A valid/ready handshake on both sides lets the pipeline stall while the unit works. Operations take one result bit per cycle.

---
 rtl/PARAMS_pkg.sv | 29 ++
 rtl/alu_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/PARAMS_pkg.sv
// -----------------------------------------------------------------------------
// PARAMS_pkg
// Shared parameters for the execute stage: datapath width, funct3 field width,
// the RV32M funct7 selector, the RV32M funct3 encodings and the state type of
// the iterative multiply/divide unit.
// -----------------------------------------------------------------------------
package PARAMS_pkg;

    localparam int WD_SIZE     = 32;
    localparam int FUNCT3_SIZE = 3;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [FUNCT3_SIZE-1:0] F3_MUL    = 3'b000;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULH   = 3'b001;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHSU = 3'b010;
    localparam logic [FUNCT3_SIZE-1:0] F3_MULHU  = 3'b011;
    localparam logic [FUNCT3_SIZE-1:0] F3_DIV    = 3'b100;
    localparam logic [FUNCT3_SIZE-1:0] F3_DIVU   = 3'b101;
    localparam logic [FUNCT3_SIZE-1:0] F3_REM    = 3'b110;
    localparam logic [FUNCT3_SIZE-1:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Iterative RV32M multiply/divide unit, one result bit per cycle. Multiplies
// are unsigned shift-add on operand magnitudes; divides are restoring. A
// single 2*WIDTH accumulator holds the product (multiply) or remainder:quotient
// (divide), and one negate stage fixes the sign of the final value.
//
// Ports
//   clk         clock
//   reset_n     synchronous active-low reset
//   valid_i     operation request
//   ready_o     unit idle, request can be accepted
//   funct3_i    RV32M operation select
//   op1_data_i  rs1 operand
//   op2_data_i  rs2 operand
//   kill_i      flush: abort any operation in flight
//   valid_o     result available
//   ready_i     consumer takes the result
//   result_o    registered result
// -----------------------------------------------------------------------------
module alu_muldiv
    import PARAMS_pkg::*;
#(
    parameter int WIDTH = WD_SIZE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [FUNCT3_SIZE-1:0] funct3_i,
    input  logic [WIDTH-1:0]       op1_data_i,
    input  logic [WIDTH-1:0]       op2_data_i,
    input  logic                   kill_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [WIDTH-1:0]       result_o
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t             r_state;
    mdu_state_t             w_state_nxt;
    logic [CW-1:0]          r_cnt;
    logic [FUNCT3_SIZE-1:0] r_funct3;
    logic [WIDTH-1:0]       r_op2;
    logic                   r_neg;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_result;

    // ---------------- accept-side decode (acts on raw inputs) ----------------
    logic             w_accept;
    logic             w_op1_signed;
    logic             w_op2_signed;
    logic             w_s1;
    logic             w_s2;
    logic [WIDTH-1:0] w_op1_mag;
    logic [WIDTH-1:0] w_op2_mag;
    logic             w_neg;
    logic             w_op2_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_special_val;

    assign w_accept     = (r_state == IDLE) && valid_i && !kill_i;
    assign w_op1_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                          (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    assign w_op2_signed = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) ||
                          (funct3_i == F3_REM);
    assign w_s1         = w_op1_signed && op1_data_i[WIDTH-1];
    assign w_s2         = w_op2_signed && op2_data_i[WIDTH-1];
    assign w_op1_mag    = w_s1 ? -op1_data_i : op1_data_i;
    assign w_op2_mag    = w_s2 ? -op2_data_i : op2_data_i;
    // Remainder follows the dividend sign; product and quotient use s1 ^ s2.
    assign w_neg        = (funct3_i[2] && funct3_i[1]) ? w_s1 : (w_s1 ^ w_s2);

    assign w_op2_zero   = (op2_data_i == '0);
    assign w_ovf        = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                          (op1_data_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (&op2_data_i);
    // Divides by zero and the signed overflow case resolve without iterating.
    assign w_special    = funct3_i[2] && (w_op2_zero || w_ovf);

    always_comb begin
        w_special_val = '0;
        if (w_op2_zero) begin
            w_special_val = funct3_i[1] ? op1_data_i : {WIDTH{1'b1}};
        end else begin
            w_special_val = funct3_i[1] ? {WIDTH{1'b0}} : op1_data_i;
        end
    end

    // ---------------- iteration step ----------------
    logic               w_is_mul;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rem_new;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_is_mul  = !r_funct3[2];

    // Shift-add: the multiplier sits in the low half and is consumed LSB
    // first; the carry of the add drops into the top bit as everything shifts
    // right, so the full product fits in 2*WIDTH bits after WIDTH steps.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_op2} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: the dividend shifts out of the low half into the
    // WIDTH+1-bit partial remainder; quotient bits shift in at the bottom.
    assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = (w_rem_sh >= {1'b0, r_op2});
    // When the trial subtract succeeds the difference is below the divisor,
    // so truncating to WIDTH bits loses nothing.
    assign w_diff    = w_rem_sh[WIDTH-1:0] - r_op2;
    assign w_rem_new = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
    assign w_div_nxt = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

    assign w_acc_nxt = w_is_mul ? w_mul_nxt : w_div_nxt;

    // ---------------- final sign fix and result select ----------------
    logic [2*WIDTH-1:0] w_sel;
    logic [2*WIDTH-1:0] w_signed;
    logic [WIDTH-1:0]   w_result;

    always_comb begin
        w_sel = '0;
        if (w_is_mul) begin
            w_sel = w_acc_nxt;
        end else if (!r_funct3[1]) begin
            w_sel = {{WIDTH{1'b0}}, w_acc_nxt[WIDTH-1:0]};
        end else begin
            w_sel = {{WIDTH{1'b0}}, w_acc_nxt[2*WIDTH-1:WIDTH]};
        end
    end

    // Negate the full 2*WIDTH value so the high half of a signed product
    // picks up the borrow from the low half.
    assign w_signed = r_neg ? -w_sel : w_sel;
    assign w_result = (w_is_mul && (r_funct3 != F3_MUL)) ?
                      w_signed[2*WIDTH-1:WIDTH] : w_signed[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (valid_i && !kill_i) begin
                    w_state_nxt = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill_i) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // kill_i and a handshake both leave; under kill the result
                // simply counts as not delivered.
                if (kill_i || ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    // NOTE: only the result and counter are reset; the operand and
    // accumulator registers are always loaded on accept before being read,
    // so resetting them would add reset fan-out for no behavioural gain.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3 <= funct3_i;
                        r_op2    <= w_op2_mag;
                        r_neg    <= w_neg;
                        r_acc    <= {{WIDTH{1'b0}}, w_op1_mag};
                        r_cnt    <= CW'(WIDTH - 1);
                        if (w_special) begin
                            r_result <= w_special_val;
                        end
                    end
                end
                CALC: begin
                    if (!kill_i) begin
                        r_acc <= w_acc_nxt;
                        if (r_cnt == '0) begin
                            r_result <= w_result;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs (decoded from state / registered) ----------------
    assign ready_o  = reset_n && (r_state == IDLE);
    assign valid_o  = (r_state == DONE);
    assign result_o = r_result;

endmodule
